// File: rtl/iseq_arbiter_pkg.sv
// Shared encodings for the instruction-sequence arbiter: FSM states and output source tags.
package iseq_arbiter_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_APP_SEQ = 1'b1
    } arb_state_t;

    // Tag bits are {is_app, is_mnt} so the register maps straight onto the two tag outputs.
    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_APP  = 2'b10,
        SRC_MNT  = 2'b01
    } src_tag_t;

endpackage

// File: rtl/iseq_arbiter_sat_wait_counter.sv
// Saturating wait counter with an equality compare against a fixed threshold.
module sat_wait_counter #(
    parameter int WAIT_W = 8,
    parameter int THRESH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [WAIT_W-1:0] THR = WAIT_W'(THRESH);

    logic [WAIT_W-1:0] count;

    // Saturates at all-ones so a long wait can never wrap back through the threshold.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == THR);

endmodule

// File: rtl/iseq_arbiter.sv
// Arbiter between application and maintenance instruction streams with atomic app sequences.
// Optional grant statistics ports are built in when ARB_STATS_EN is defined.
module iseq_arbiter
    import iseq_arbiter_pkg::*;
#(
    parameter int MAX_MAINT_WAIT = 64,
    parameter int WAIT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               app_en,
    input  logic [INSTR_W-1:0] app_instr,
    input  logic               app_last,
    output logic               app_ack,
    input  logic               maint_en,
    input  logic [INSTR_W-1:0] maint_instr,
    output logic               maint_ack,
    output logic               out_en,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               out_ready,
    output logic               out_is_app,
    output logic               out_is_mnt,
    output logic               seq_open,
    output logic               maint_starved
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]        app_grant_cnt,
    output logic [31:0]        maint_grant_cnt
`endif
);

    // Handshake: each source holds en/data until its ack; the output holds out_en/out_instr
    // until out_en & out_ready, and a new instruction is taken only when the slot is free.
    arb_state_t state;
    src_tag_t   tag;
    logic       slot;
    logic       wait_hit;

    assign slot = ~out_en | out_ready;

    always_comb begin
        app_ack   = 1'b0;
        maint_ack = 1'b0;
        if (!rst && slot) begin
            if (state == ARB_IDLE) begin
                maint_ack = maint_en;
                app_ack   = app_en & ~maint_en;
            end else begin
                app_ack   = app_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            out_en    <= 1'b0;
            out_instr <= '0;
            tag       <= SRC_NONE;
        end else begin
            if (app_ack) begin
                state <= app_last ? ARB_IDLE : ARB_APP_SEQ;
            end

            if (app_ack) begin
                out_en    <= 1'b1;
                out_instr <= app_instr;
                tag       <= SRC_APP;
            end else if (maint_ack) begin
                out_en    <= 1'b1;
                out_instr <= maint_instr;
                tag       <= SRC_MNT;
            end else if (out_ready) begin
                out_en    <= 1'b0;
                tag       <= SRC_NONE;
            end
        end
    end

    // seq_open is the FSM state itself, so it doubles as the state observation point.
    assign seq_open                 = (state == ARB_APP_SEQ);
    assign {out_is_app, out_is_mnt} = tag;

    sat_wait_counter #(
        .WAIT_W (WAIT_W),
        .THRESH (MAX_MAINT_WAIT)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .clr (maint_ack | ~maint_en),
        .inc (maint_en & ~maint_ack),
        .hit (wait_hit)
    );

    always_ff @(posedge clk) begin
        if (rst || maint_ack) begin
            maint_starved <= 1'b0;
        end else if (wait_hit) begin
            maint_starved <= 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            app_grant_cnt   <= '0;
            maint_grant_cnt <= '0;
        end else begin
            if (app_ack)   app_grant_cnt   <= app_grant_cnt + 32'd1;
            if (maint_ack) maint_grant_cnt <= maint_grant_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iseq_arbiter.sv
// Directed testbench for iseq_arbiter with MAX_MAINT_WAIT=4.
module tb_iseq_arbiter;

    logic        clk;
    logic        rst;
    logic        app_en;
    logic [31:0] app_instr;
    logic        app_last;
    logic        app_ack;
    logic        maint_en;
    logic [31:0] maint_instr;
    logic        maint_ack;
    logic        out_en;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        out_is_app;
    logic        out_is_mnt;
    logic        seq_open;
    logic        maint_starved;
`ifdef ARB_STATS_EN
    logic [31:0] app_grant_cnt;
    logic [31:0] maint_grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    iseq_arbiter #(
        .MAX_MAINT_WAIT (4),
        .WAIT_W         (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .app_en        (app_en),
        .app_instr     (app_instr),
        .app_last      (app_last),
        .app_ack       (app_ack),
        .maint_en      (maint_en),
        .maint_instr   (maint_instr),
        .maint_ack     (maint_ack),
        .out_en        (out_en),
        .out_instr     (out_instr),
        .out_ready     (out_ready),
        .out_is_app    (out_is_app),
        .out_is_mnt    (out_is_mnt),
        .seq_open      (seq_open),
        .maint_starved (maint_starved)
`ifdef ARB_STATS_EN
        ,
        .app_grant_cnt   (app_grant_cnt),
        .maint_grant_cnt (maint_grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Registered outputs; tags given as {is_app, is_mnt}.
    task automatic chk_out(input string tag, input logic en, input logic [31:0] instr,
                           input logic [1:0] src);
        chk({tag, ".out_en"}, 32'(out_en), 32'(en));
        chk({tag, ".out_instr"}, out_instr, instr);
        chk({tag, ".tags"}, 32'({out_is_app, out_is_mnt}), 32'(src));
    endtask

    task automatic chk_acks(input string tag, input logic a, input logic m);
        #1;
        chk({tag, ".app_ack"}, 32'(app_ack), 32'(a));
        chk({tag, ".maint_ack"}, 32'(maint_ack), 32'(m));
    endtask

    initial begin
        rst         = 1'b1;
        app_en      = 1'b1;
        app_instr   = 32'hDEAD_BEEF;
        app_last    = 1'b1;
        maint_en    = 1'b0;
        maint_instr = 32'h0;
        out_ready   = 1'b1;

        // Reset: acks gated, all outputs cleared.
        tick();
        chk_acks("rst_hold", 1'b0, 1'b0);
        tick();
        app_en = 1'b0;
        rst    = 1'b0;
        chk_out("rst", 1'b0, 32'h0, 2'b00);
        chk("rst.seq_open", 32'(seq_open), 32'd0);
        chk("rst.starved", 32'(maint_starved), 32'd0);

        // Single-instruction app sequence.
        app_en = 1'b1; app_instr = 32'h0000_1234; app_last = 1'b1;
        chk_acks("single.c0", 1'b1, 1'b0);
        tick();
        app_en = 1'b0;
        chk_out("single.c1", 1'b1, 32'h0000_1234, 2'b10);
        chk("single.seq_open", 32'(seq_open), 32'd0);
        chk_acks("single.idle", 1'b0, 1'b0);
        tick();
        chk_out("single.c2", 1'b0, 32'h0000_1234, 2'b00);

        // Three-instruction sequence; maintenance arrives after the first ack.
        app_en = 1'b1; app_instr = 32'h0000_00A1; app_last = 1'b0;
        chk_acks("seq.a1", 1'b1, 1'b0);
        tick();
        app_instr = 32'h0000_00A2;
        maint_en = 1'b1; maint_instr = 32'h0000_00E1;
        chk("seq.open1", 32'(seq_open), 32'd1);
        chk_out("seq.out_a1", 1'b1, 32'h0000_00A1, 2'b10);
        chk_acks("seq.a2", 1'b1, 1'b0);
        tick();
        app_instr = 32'h0000_00A3; app_last = 1'b1;
        chk_out("seq.out_a2", 1'b1, 32'h0000_00A2, 2'b10);
        chk_acks("seq.a3", 1'b1, 1'b0);
        tick();
        app_en = 1'b0;
        chk_out("seq.out_a3", 1'b1, 32'h0000_00A3, 2'b10);
        chk("seq.closed", 32'(seq_open), 32'd0);
        chk_acks("seq.m1", 1'b0, 1'b1);
        tick();
        maint_en = 1'b0;
        chk_out("seq.out_m1", 1'b1, 32'h0000_00E1, 2'b01);
        chk_acks("seq.quiet", 1'b0, 1'b0);
        tick();
        chk("seq.drain", 32'(out_en), 32'd0);

        // Simultaneous requests in IDLE: maintenance first, then app.
        app_en = 1'b1; app_instr = 32'h0000_00B1; app_last = 1'b1;
        maint_en = 1'b1; maint_instr = 32'h0000_00E2;
        chk_acks("tie.first", 1'b0, 1'b1);
        tick();
        maint_en = 1'b0;
        chk_out("tie.out_m", 1'b1, 32'h0000_00E2, 2'b01);
        chk_acks("tie.second", 1'b1, 1'b0);
        tick();
        app_en = 1'b0;
        chk_out("tie.out_a", 1'b1, 32'h0000_00B1, 2'b10);
        tick();

        // Backpressure: 5 stalled cycles hold the output and block acks.
        app_en = 1'b1; app_instr = 32'h0000_00C1; app_last = 1'b1;
        chk_acks("bp.c1", 1'b1, 1'b0);
        tick();
        out_ready = 1'b0;
        app_instr = 32'h0000_00C2;
        for (int i = 0; i < 5; i++) begin
            chk_acks("bp.stall", 1'b0, 1'b0);
            chk_out("bp.hold", 1'b1, 32'h0000_00C1, 2'b10);
            tick();
        end
        out_ready = 1'b1;
        chk_acks("bp.release", 1'b1, 1'b0);
        tick();
        app_en = 1'b0;
        chk_out("bp.out_c2", 1'b1, 32'h0000_00C2, 2'b10);
        tick();

        // Starvation: sequence held open by a gap while maintenance waits.
        app_en = 1'b1; app_instr = 32'h0000_00D1; app_last = 1'b0;
        chk_acks("stv.d1", 1'b1, 1'b0);
        tick();
        app_en = 1'b0;
        maint_en = 1'b1; maint_instr = 32'h0000_00E4;
        chk_acks("stv.k0", 1'b0, 1'b0);
        chk("stv.k0_flag", 32'(maint_starved), 32'd0);
        tick();
        tick();
        tick();
        chk("stv.k3_flag", 32'(maint_starved), 32'd0);
        tick();
        tick();
        chk("stv.k5_flag", 32'(maint_starved), 32'd1);
        chk("stv.open", 32'(seq_open), 32'd1);
        app_en = 1'b1; app_instr = 32'h0000_00D2; app_last = 1'b1;
        chk_acks("stv.d2", 1'b1, 1'b0);
        tick();
        app_en = 1'b0;
        chk_acks("stv.m", 1'b0, 1'b1);
        chk("stv.flag_at_ack", 32'(maint_starved), 32'd1);
        tick();
        maint_en = 1'b0;
        chk("stv.flag_clr", 32'(maint_starved), 32'd0);
        chk_out("stv.out_m", 1'b1, 32'h0000_00E4, 2'b01);
        tick();

`ifdef ARB_STATS_EN
        chk("stats.app", app_grant_cnt, 32'd9);
        chk("stats.maint", maint_grant_cnt, 32'd3);
`endif

        // Reset in the middle of an open sequence with a held output.
        app_en = 1'b1; app_instr = 32'h0000_00F1; app_last = 1'b0;
        chk_acks("rsq.f1", 1'b1, 1'b0);
        tick();
        out_ready = 1'b0;
        app_instr = 32'h0000_00F2;
        chk("rsq.open", 32'(seq_open), 32'd1);
        rst = 1'b1;
        chk_acks("rsq.gated", 1'b0, 1'b0);
        tick();
        rst = 1'b0; app_en = 1'b0; out_ready = 1'b1;
        chk_out("rsq.after", 1'b0, 32'h0, 2'b00);
        chk("rsq.seq_open", 32'(seq_open), 32'd0);
        chk("rsq.starved", 32'(maint_starved), 32'd0);
`ifdef ARB_STATS_EN
        chk("rsq.app_cnt", app_grant_cnt, 32'd0);
        chk("rsq.maint_cnt", maint_grant_cnt, 32'd0);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
